// File: rtl/crc_seq_pkg.sv
// rtl/crc_seq_pkg.sv - shared state encoding, report command code and header field helpers
package crc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_BODY   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_REPORT = 3'd4
   } seq_state_e;

   localparam logic [3:0] CMD_REPORT_DFLT = 4'hE;

   // Header byte layout: CRC_M in the upper nibble, CMD in the lower nibble.
   function automatic logic [3:0] hdr_crc_m(input logic [7:0] hdr);
      return hdr[7:4];
   endfunction

   function automatic logic [3:0] hdr_cmd(input logic [7:0] hdr);
      return hdr[3:0];
   endfunction

endpackage

// File: rtl/crc_seq_sat_cnt.sv
// rtl/crc_seq_sat_cnt.sv - saturating event counter
module crc_seq_sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         sys_clk,
   input  logic         sys_resetb,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Increment on request, sticking at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/crc_frame_sequencer.sv
// rtl/crc_frame_sequencer.sv - receive frame sequencer driving the serial CRC checker
module crc_frame_sequencer
   import crc_seq_pkg::*;
#(
   parameter int unsigned PAYLOAD_BYTES = 2,
   parameter int unsigned REPORT_BITS   = 16,
   parameter int unsigned TIMEOUT       = 255,
   parameter int unsigned CNT_W         = 8,
   parameter logic [3:0]  CMD_REPORT    = CMD_REPORT_DFLT
) (
   input  logic                   sys_clk,
   input  logic                   sys_resetb,
   input  logic                   rx_sof,
   input  logic                   rx_bit,
   input  logic                   rx_bit_vld,
   output logic                   crc_enable,
   output logic                   crc_data,
   output logic [3:0]             crc_cmd,
   output logic [3:0]             crc_m,
   output logic                   crc_init,
   input  logic                   crc_cts,
   input  logic                   crc_cts_err,
   output logic                   frm_ok,
   output logic                   frm_err,
   output logic                   frm_abort,
   output logic [3:0]             frm_cmd,
   output logic [REPORT_BITS-1:0] rpt_data,
   output logic                   rpt_vld,
   output logic [CNT_W-1:0]       ok_cnt,
   output logic [CNT_W-1:0]       err_cnt,
   output logic                   busy
);

   localparam int unsigned BODY_BITS = PAYLOAD_BYTES * 8;
   localparam int unsigned MAX_BITS  = (BODY_BITS > REPORT_BITS) ? BODY_BITS : REPORT_BITS;
   localparam int unsigned BCNT_W    = $clog2(MAX_BITS);
   localparam int unsigned IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   seq_state_e             state_q, state_d;
   logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic [7:0]             hdr_q, hdr_d, hdr_new;
   logic [REPORT_BITS:0]   rpt_new;
   logic [REPORT_BITS-1:0] rpt_sh_q, rpt_sh_d, rpt_data_q, rpt_data_d;
   logic [3:0]             crc_m_q, crc_m_d, crc_cmd_q, crc_cmd_d, frm_cmd_q, frm_cmd_d;
   logic                   crc_enable_q, crc_enable_d, crc_data_q, crc_data_d;
   logic                   crc_init_q, crc_init_d, rpt_vld_q, rpt_vld_d;
   logic                   frm_ok_q, frm_ok_d, frm_err_q, frm_err_d, frm_abort_q, frm_abort_d;
   logic                   in_frame, sof_abort, init_slot;

   assign hdr_new   = {hdr_q[6:0], rx_bit};
   assign rpt_new   = {rpt_sh_q, rx_bit};
   assign in_frame  = (state_q == ST_HDR) || (state_q == ST_BODY) || (state_q == ST_REPORT);
   // CHECK waits for the last forwarded bit to drain before clearing the checker.
   assign init_slot = (state_q == ST_CHECK) && !crc_enable_q;

   // Next-state, bit framing, forwarding and verdict decode.
   always_comb begin
      state_d      = state_q;
      bcnt_d       = bcnt_q;
      idle_d       = idle_q;
      hdr_d        = hdr_q;
      rpt_sh_d     = rpt_sh_q;
      rpt_data_d   = rpt_data_q;
      crc_m_d      = crc_m_q;
      crc_cmd_d    = crc_cmd_q;
      frm_cmd_d    = frm_cmd_q;
      crc_enable_d = 1'b0;
      crc_data_d   = crc_data_q;
      crc_init_d   = 1'b0;
      frm_ok_d     = 1'b0;
      frm_err_d    = 1'b0;
      frm_abort_d  = 1'b0;
      rpt_vld_d    = 1'b0;
      sof_abort    = 1'b0;
      if (rx_sof && rx_bit_vld && (state_q != ST_CHECK)) begin
         // A new frame always wins; an open frame is aborted and the checker
         // cleared in this cycle so the new header bit lands in a clean CRC.
         sof_abort    = in_frame;
         frm_abort_d  = in_frame;
         state_d      = ST_HDR;
         bcnt_d       = BCNT_W'(6);
         idle_d       = '0;
         hdr_d        = {7'd0, rx_bit};
         crc_enable_d = 1'b1;
         crc_data_d   = rx_bit;
      end else begin
         case (state_q)
            ST_HDR, ST_BODY, ST_REPORT: begin
               if (rx_bit_vld) begin
                  crc_enable_d = 1'b1;
                  crc_data_d   = rx_bit;
                  idle_d       = '0;
                  bcnt_d       = (bcnt_q == '0) ? bcnt_q : bcnt_q - 1'b1;
                  if (state_q == ST_HDR) begin
                     hdr_d = hdr_new;
                     if (bcnt_q == '0) begin
                        crc_m_d   = hdr_crc_m(hdr_new);
                        crc_cmd_d = hdr_cmd(hdr_new);
                        bcnt_d    = BCNT_W'(BODY_BITS - 1);
                        state_d   = ST_BODY;
                     end
                  end else if (state_q == ST_BODY) begin
                     if (bcnt_q == '0) begin
                        state_d = ST_CHECK;
                     end
                  end else begin
                     rpt_sh_d = rpt_new[REPORT_BITS-1:0];
                     if (bcnt_q == '0) begin
                        rpt_data_d = rpt_new[REPORT_BITS-1:0];
                        rpt_vld_d  = 1'b1;
                        state_d    = ST_IDLE;
                     end
                  end
               end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                  frm_abort_d = 1'b1;
                  crc_init_d  = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
            ST_CHECK: begin
               if (rx_bit_vld) begin
                  // Bit dropped; clear the checker later only if it was not cleared now.
                  frm_abort_d = 1'b1;
                  crc_init_d  = crc_enable_q;
                  state_d     = ST_IDLE;
               end else if (init_slot) begin
                  frm_cmd_d = crc_cmd_q;
                  if (crc_cts && !crc_cts_err) begin
                     frm_ok_d = 1'b1;
                     bcnt_d   = BCNT_W'(REPORT_BITS - 1);
                     idle_d   = '0;
                     rpt_sh_d = '0;
                     state_d  = (crc_cmd_q == CMD_REPORT) ? ST_REPORT : ST_IDLE;
                  end else begin
                     frm_err_d = 1'b1;
                     state_d   = ST_IDLE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         state_q      <= ST_IDLE;
         bcnt_q       <= '0;
         idle_q       <= '0;
         hdr_q        <= '0;
         rpt_sh_q     <= '0;
         rpt_data_q   <= '0;
         crc_m_q      <= '0;
         crc_cmd_q    <= '0;
         frm_cmd_q    <= '0;
         crc_enable_q <= 1'b0;
         crc_data_q   <= 1'b0;
         crc_init_q   <= 1'b0;
         frm_ok_q     <= 1'b0;
         frm_err_q    <= 1'b0;
         frm_abort_q  <= 1'b0;
         rpt_vld_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bcnt_q       <= bcnt_d;
         idle_q       <= idle_d;
         hdr_q        <= hdr_d;
         rpt_sh_q     <= rpt_sh_d;
         rpt_data_q   <= rpt_data_d;
         crc_m_q      <= crc_m_d;
         crc_cmd_q    <= crc_cmd_d;
         frm_cmd_q    <= frm_cmd_d;
         crc_enable_q <= crc_enable_d;
         crc_data_q   <= crc_data_d;
         crc_init_q   <= crc_init_d;
         frm_ok_q     <= frm_ok_d;
         frm_err_q    <= frm_err_d;
         frm_abort_q  <= frm_abort_d;
         rpt_vld_q    <= rpt_vld_d;
      end
   end

   crc_seq_sat_cnt #(.W(CNT_W)) u_ok_cnt (
      .sys_clk    (sys_clk),
      .sys_resetb (sys_resetb),
      .inc        (frm_ok_d),
      .cnt        (ok_cnt)
   );

   crc_seq_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .sys_clk    (sys_clk),
      .sys_resetb (sys_resetb),
      .inc        (frm_err_d | frm_abort_d),
      .cnt        (err_cnt)
   );

   // The sof-abort clear displaces the stale bit of the aborted frame.
   assign crc_enable = crc_enable_q & ~sof_abort;
   assign crc_init   = crc_init_q | init_slot | sof_abort;
   assign crc_data   = crc_data_q;
   assign crc_cmd    = crc_cmd_q;
   assign crc_m      = crc_m_q;
   assign frm_ok     = frm_ok_q;
   assign frm_err    = frm_err_q;
   assign frm_abort  = frm_abort_q;
   assign frm_cmd    = frm_cmd_q;
   assign rpt_data   = rpt_data_q;
   assign rpt_vld    = rpt_vld_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
